// File: rtl/sample_decompressor.sv
// Run-length sample decompressor: literals, with a count word after each pair of equal literals.
// Optional SAMPLE_DECOMPRESSOR_INDEX_EN adds a 40-bit delivered-sample counter output.
module sample_decompressor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [31:0] pipeline_state
`ifdef SAMPLE_DECOMPRESSOR_INDEX_EN
  ,
  output logic [39:0] sample_index
`endif
);

  typedef enum logic [1:0] {
    st_init   = 2'd0,
    st_lit    = 2'd1,
    st_count  = 2'd2,
    st_expand = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] prev_q, prev_d;
  logic [15:0] rem_q, rem_d;
  logic        cont_q, cont_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        slot_free;
  logic        accept;

  assign slot_free = !out_valid_q || out_ready;
  // rst_n gating keeps in_ready low for the whole reset window, not just after the first edge.
  assign in_ready  = rst_n && !clear && (state_q != st_expand) && slot_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    rem_d       = rem_q;
    cont_d      = cont_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      state_d     = st_init;
      out_valid_d = 1'b0;
      rem_d       = '0;
      cont_d      = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      unique case (state_q)
        st_init: begin
          if (accept) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
            prev_d      = in_data;
            state_d     = st_lit;
          end
        end
        st_lit: begin
          if (accept) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
            prev_d      = in_data;
            if (in_data == prev_q) state_d = st_count;
          end
        end
        st_count: begin
          if (accept) begin
            if (in_data == 16'h0000) begin
              state_d = st_lit;
            end else begin
              rem_d   = in_data;
              cont_d  = (in_data == 16'hFFFF);
              state_d = st_expand;
            end
          end
        end
        st_expand: begin
          // rem only moves when a repeat actually lands in the output register.
          if (slot_free) begin
            out_data_d  = prev_q;
            out_valid_d = 1'b1;
            rem_d       = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = cont_q ? st_count : st_lit;
          end
        end
        default: state_d = st_init;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= st_init;
      rem_q       <= '0;
      cont_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cont_q      <= cont_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Datapath registers carry no reset; their contents are qualified by out_valid/state.
  always_ff @(posedge clk) begin
    prev_q     <= prev_d;
    out_data_q <= out_data_d;
  end

  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign busy           = (state_q == st_expand) || out_valid_q;
  assign pipeline_state = {state_q, cont_q, 13'b0, rem_q};

`ifdef SAMPLE_DECOMPRESSOR_INDEX_EN
  logic [39:0] index_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= '0;
    end else if (clear) begin
      index_q <= '0;
    end else if (out_valid_q && out_ready) begin
      index_q <= index_q + 40'd1;
    end
  end

  assign sample_index = index_q;
`endif

endmodule

// File: tb/tb_sample_decompressor.sv
// Directed bench for sample_decompressor: literals, runs, long counts, stalls, clear and reset.
module tb_sample_decompressor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic [31:0] pipeline_state;
`ifdef SAMPLE_DECOMPRESSOR_INDEX_EN
  logic [39:0] sample_index;
`endif

  int          total = 0;
  int          bad = 0;
  logic        toggle = 1'b0;
  logic [15:0] got[$];
  logic [15:0] expv[$];
  logic        stall_prev = 1'b0;
  logic [15:0] held_d = 16'h0;

  sample_decompressor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .pipeline_state (pipeline_state)
`ifdef SAMPLE_DECOMPRESSOR_INDEX_EN
    ,
    .sample_index   (sample_index)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Collects delivered samples and checks that a stalled output holds steady.
  always @(negedge clk) begin
    if (stall_prev) begin
      check("stall hold valid", 64'(out_valid), 64'h1);
      check("stall hold data", 64'(out_data), 64'(held_d));
    end
    stall_prev = out_valid && !out_ready && !clear && rst_n;
    held_d = out_data;
    if (out_valid && out_ready) got.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle) out_ready = ~out_ready;
  endtask

  task automatic send(input logic [15:0] w, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    in_data = w;
    in_valid = 1'b1;
    while (!acc && waited <= 70000) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (!acc) waited++;
    end
    in_valid = 1'b0;
    check($sformatf("accept %0h", w), 64'(acc), 64'h1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic check_got(input string tag);
    check({tag, " count"}, 64'(got.size()), 64'(expv.size()));
    for (int i = 0; i < expv.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(expv[i]));
  endtask

  initial begin
    int w;
    int nines;

    // Reset values
    #2;
    check("rst in_ready", 64'(in_ready), 64'h0);
    check("rst out_valid", 64'(out_valid), 64'h0);
    check("rst busy", 64'(busy), 64'h0);
    check("rst pipeline_state", 64'(pipeline_state), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post-rst in_ready", 64'(in_ready), 64'h1);
`ifdef SAMPLE_DECOMPRESSOR_INDEX_EN
    check("rst sample_index", 64'(sample_index), 64'h0);
`endif

    // Plain literals, one cycle latency each
    got.delete();
    send(16'h0001, w);
    check("lit1 valid", 64'(out_valid), 64'h1);
    check("lit1 data", 64'(out_data), 64'h1);
    send(16'h0002, w);
    check("lit2 data", 64'(out_data), 64'h2);
    send(16'h0003, w);
    check("lit3 data", 64'(out_data), 64'h3);
    tick();
    check("lit idle valid", 64'(out_valid), 64'h0);
    check("lit pipeline_state", 64'(pipeline_state), 64'h4000_0000);
    expv = '{16'h1, 16'h2, 16'h3};
    check_got("lits");

    // Short run 5,5,3 then literal 7
    do_clear();
    got.delete();
    send(16'h0005, w);
    send(16'h0005, w);
    send(16'h0003, w);
    check("run3 pipeline_state", 64'(pipeline_state), 64'hC000_0003);
    check("run3 in_ready", 64'(in_ready), 64'h0);
    check("run3 busy", 64'(busy), 64'h1);
    send(16'h0007, w);
    check("run3 blocked cycles", 64'(w), 64'd3);
    repeat (2) tick();
    expv = '{16'h5, 16'h5, 16'h5, 16'h5, 16'h5, 16'h7};
    check_got("run3");
`ifdef SAMPLE_DECOMPRESSOR_INDEX_EN
    check("index after run3", 64'(sample_index), 64'd6);
    do_clear();
    check("index after clear", 64'(sample_index), 64'd0);
`endif

    // Count 0 and count 1 boundaries
    do_clear();
    got.delete();
    send(16'h0008, w);
    send(16'h0008, w);
    send(16'h0000, w);
    send(16'h0008, w);
    send(16'h0001, w);
    send(16'h0003, w);
    repeat (3) tick();
    expv = '{16'h8, 16'h8, 16'h8, 16'h8, 16'h3};
    check_got("cnt0_1");

    // Continued count 0xFFFF followed by count 0
    do_clear();
    got.delete();
    send(16'h0009, w);
    send(16'h0009, w);
    send(16'hFFFF, w);
    check("ffff pipeline_state", 64'(pipeline_state), 64'hE000_FFFF);
    send(16'h0000, w);
    check("ffff blocked cycles", 64'(w), 64'd65535);
    send(16'h0001, w);
    repeat (3) tick();
    check("ffff count", 64'(got.size()), 64'd65538);
    nines = 0;
    for (int i = 0; i < 65537 && i < got.size(); i++)
      if (got[i] == 16'h0009) nines++;
    check("ffff nines", 64'(nines), 64'd65537);
    if (got.size() == 65538) check("ffff last", 64'(got[65537]), 64'h1);

    // Output back-pressure toggling every cycle
    do_clear();
    got.delete();
    toggle = 1'b1;
    send(16'h0005, w);
    send(16'h0005, w);
    send(16'h0003, w);
    repeat (20) tick();
    toggle = 1'b0;
    out_ready = 1'b1;
    tick();
    expv = '{16'h5, 16'h5, 16'h5, 16'h5, 16'h5};
    check_got("stall");

    // Clear in the middle of a long run, with a word offered that cycle
    do_clear();
    got.delete();
    send(16'h0004, w);
    send(16'h0004, w);
    send(16'h0100, w);
    repeat (3) tick();
    check("pre-clear busy", 64'(busy), 64'h1);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h0055;
    #1;
    check("clear in_ready", 64'(in_ready), 64'h0);
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear out_valid", 64'(out_valid), 64'h0);
    check("clear pipeline_state", 64'(pipeline_state), 64'h0);
    check("clear busy", 64'(busy), 64'h0);
    got.delete();
    repeat (4) tick();
    check("clear no output", 64'(got.size()), 64'd0);
    send(16'h00AA, w);
    check("fresh AA", 64'(out_data), 64'hAA);
    send(16'h00BB, w);
    check("fresh BB", 64'(out_data), 64'hBB);
    tick();
    expv = '{16'hAA, 16'hBB};
    check_got("fresh");

    // Asynchronous reset in the middle of a run
    do_clear();
    got.delete();
    send(16'h0006, w);
    send(16'h0006, w);
    send(16'h0010, w);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("mid rst out_valid", 64'(out_valid), 64'h0);
    check("mid rst in_ready", 64'(in_ready), 64'h0);
    check("mid rst pipeline_state", 64'(pipeline_state), 64'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    got.delete();
    repeat (4) tick();
    check("rst no output", 64'(got.size()), 64'd0);
    send(16'h0042, w);
    check("post-rst lit valid", 64'(out_valid), 64'h1);
    check("post-rst lit data", 64'(out_data), 64'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_decompressor.md
SAMPLE_DECOMPRESSOR -- requirements
Module: sample_decompressor

Interface
REQ-001 SHALL have no parameters; all widths fixed (16-bit words).
REQ-002 SHALL have clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have clear  input  1  synchronous restart at page boundary.
REQ-005 SHALL have in_data  input  16  compressed word.
REQ-006 SHALL have in_valid  input  1  in_data valid.
REQ-007 SHALL have in_ready  output  1  word accepted when in_valid && in_ready.
REQ-008 SHALL have out_data  output  16  reconstructed sample.
REQ-009 SHALL have out_valid  output  1  out_data valid.
REQ-010 SHALL have out_ready  input  1  sample consumed when out_valid && out_ready.
REQ-011 SHALL have busy  output  1  high when state is st_expand or out_valid is high.
REQ-012 SHALL have pipeline_state  output  32  {state[1:0], cont, 13'b0, rem[15:0]}.

Function
REQ-013 Stream format SHALL be: literal words; two consecutive equal literals SHALL be followed by one count word. Count n<0xFFFF means n further repeats, then back to literals. Count 0xFFFF means 65535 further repeats, then another count word.
REQ-014 States SHALL be st_init, st_lit, st_count and st_expand, with registers prev[15:0], rem[15:0] and cont.
REQ-015 in_ready SHALL equal (state != st_expand) && (!out_valid || out_ready), combinationally.
REQ-016 st_init, word w accepted: out_data<=w, out_valid<=1, prev<=w, go to st_lit.
REQ-017 st_lit, word w accepted: out_data<=w, out_valid<=1, prev<=w. If w==prev, go to st_count; otherwise stay in st_lit.
REQ-018 st_count, word n accepted: no output. If n==0, go to st_lit. Otherwise rem<=n, cont<=(n==16'hFFFF), go to st_expand.
REQ-019 st_expand: each cycle the output slot is free (!out_valid || out_ready), SHALL emit out_data<=prev, out_valid<=1, rem<=rem-1.
REQ-020 On the emit where rem==1, the next state SHALL be st_count if cont, else st_lit.
REQ-021 Latency SHALL be one cycle from accepted literal (or expand slot) to out_valid; throughput one sample per cycle while out_ready is high.
REQ-022 When out_valid && !out_ready, out_data and out_valid SHALL hold unchanged, and rem SHALL not decrement.
REQ-023 When out_valid && out_ready and no new sample is produced, out_valid SHALL fall on the next cycle.
REQ-024 clear SHALL have priority over every other event: next cycle state=st_init, out_valid=0, rem=0, cont=0. A word offered in the same cycle SHALL be dropped, and in_ready SHALL be 0 that cycle.
REQ-025 rem arithmetic SHALL be 16-bit unsigned; no wrap occurs because st_expand is entered only with rem>=1.

Reset
REQ-026 On rst_n low: state=st_init, out_valid=0, rem=0, cont=0, in_ready=0 while in reset; out_data and prev are don't-care.
REQ-027 On reset release, first accepted word SHALL be treated as a literal (st_init).
REQ-028 Reset mid-expand SHALL abandon the run with no further outputs.

Configuration
REQ-029 Macro SAMPLE_DECOMPRESSOR_INDEX_EN defined: SHALL add output sample_index[39:0]. Counts samples on each out_valid && out_ready, zeroed by rst_n and by clear, wraps modulo 2^40.
REQ-030 Macro SAMPLE_DECOMPRESSOR_INDEX_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-031 Words 0x0001, 0x0002, 0x0003 with out_ready=1 -> outputs 1, 2, 3, each one cycle after acceptance.
REQ-032 Words 0x0005, 0x0005, 0x0003, 0x0007 -> outputs 5,5,5,5,5,7; in_ready low during the 3 expand cycles.
REQ-033 Words 0x0009, 0x0009, 0xFFFF, 0x0000, 0x0001 -> 65537 samples of 0x0009, then 0x0001.
REQ-034 Run 5,5,0x0003 with out_ready toggling 1/0 -> out_data stable while stalled; exactly 5 fives delivered.
REQ-035 clear asserted mid-expand of count 0x0100 -> out_valid=0 next cycle. Then words 0x00AA, 0x00BB -> outputs 0xAA, 0xBB as fresh literals.
REQ-036 With SAMPLE_DECOMPRESSOR_INDEX_EN, after REQ-032 stimulus -> sample_index=6; after clear -> 0.
